mux8_rr_arbiter: RTL
====================

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 Parameter PTR_INIT, default 3'd0: round-robin pointer value loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req  input  8  per-requester request, bit k = requester k; level-held until its transfer.
REQ-005 i  input  8  per-requester data bit, bit k = data of requester k.
REQ-006 out_ready  input  1  downstream accepts out_data this cycle.
REQ-007 grant  output  8  one-hot grant, registered; all-zero when idle.
REQ-008 s  output  3  registered mux select = index of granted requester.
REQ-009 out_data  output  1  equals i[s] combinationally through the mux while out_valid=1; 0 otherwise.
REQ-010 out_valid  output  1  registered; high while a grant is held.

Function
REQ-011 FSM SHALL have exactly two states: IDLE (no grant) and BUSY (grant held, out_valid=1).
REQ-012 Transfer SHALL occur in any cycle with out_valid=1 and out_ready=1; no other condition completes a grant.
REQ-013 Arbitration: winner = first k with req[k]=1, searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod-8 wrap).
REQ-014 IDLE with req!=0 at edge N SHALL move to BUSY, load s=winner, grant=1<<winner, out_valid=1, visible after edge N (1-cycle latency).
REQ-015 IDLE with req=0 SHALL remain IDLE; s holds its previous value, grant=0, out_valid=0.
REQ-016 BUSY without transfer SHALL hold s, grant, out_valid unchanged, even if the granted req drops or higher-priority req rises (no preemption, no withdrawal).
REQ-017 On transfer, ptr SHALL become (s+1) mod 8, so 7 wraps to 0.
REQ-018 On transfer, re-arbitration SHALL use the current-cycle req and the updated ptr: if any bit set, stay BUSY with the new winner at the next edge (back-to-back, zero idle cycles); else go IDLE with grant=0, out_valid=0.
REQ-019 The just-served requester SHALL have lowest priority at re-arbitration; if it alone still requests it SHALL be granted again.
REQ-020 Fairness: with all 8 req held high and out_ready=1, grants SHALL rotate k, k+1, ... with each requester served exactly once per 8 transfers.
REQ-021 ptr SHALL change only on transfer and reset.
REQ-022 grant SHALL be one-hot or zero at all times; grant!=0 iff out_valid=1.

Reset
REQ-023 rst_n=0 sampled at an edge SHALL force IDLE, ptr=PTR_INIT, s=3'd0, grant=8'd0, out_valid=0, out_data=0, regardless of state or in-flight grant.
REQ-024 A grant pending at reset SHALL be discarded with no transfer; first arbitration occurs at the first edge with rst_n=1.

Structure
REQ-025 State encodings (IDLE, BUSY) and requester count (8) and select width (3) SHALL be `define constants in a shared include file used by both RTL and bench.
REQ-026 Data path SHALL instantiate the existing multiplexer8to1 as the single sub-module (i to .i, s to .s), gated by out_valid for out_data.
REQ-027 Arbitration search SHALL be combinational; s, grant, out_valid, ptr, state SHALL be the only registers.

Verification
REQ-028 Reset: rst_n=0 two cycles, req=8'hFF -> grant=0, out_valid=0, s=0; after release, grant=8'h01 one cycle later.
REQ-029 Single request: req=8'b0010_0000, i=8'b0010_0000, out_ready=1 -> grant=8'h20, s=3'd5, out_data=1; next winner priority starts at 6.
REQ-030 Rotation: req=8'hFF, out_ready=1, PTR_INIT=0 -> s sequence 0,1,...,7,0 back-to-back, out_valid continuously high.
REQ-031 Backpressure: req=8'h81, out_ready=0 five cycles -> grant=8'h01 held, s=0 stable; raise out_ready -> next grant 8'h80, then 8'h01.
REQ-032 Wrap/lock: ptr=7 via serving requester 6, req=8'h41 -> grant=8'h01 (wrap past 7), not 8'h40.
REQ-033 Mid-operation reset: BUSY with grant=8'h04, rst_n=0 one cycle -> IDLE, grant=0, ptr=PTR_INIT, no transfer counted.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mux8_rr_arbiter_pkg
// Types, constants and helper functions for mux8_rr_arbiter.
//   state_t  : two-state FSM encoding (IDLE / BUSY)
//   arb_t    : arbitration result {found, idx}
//   rr_pick  : combinational round-robin search starting at a pointer
//   onehot   : index -> one-hot grant vector
// ----------------------------------------------------------------------------
`include "mux8_rr_arbiter_defs.svh"

package mux8_rr_arbiter_pkg;

    localparam int unsigned NUM_REQ = `MUX8_RR_NUM_REQ;
    localparam int unsigned SEL_W   = `MUX8_RR_SEL_W;

    typedef enum logic [0:0] {
        IDLE = `MUX8_RR_ST_IDLE,
        BUSY = `MUX8_RR_ST_BUSY
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } arb_t;

    // First set request bit at ptr, ptr+1, ... with mod-8 wrap.
    // The index sum is truncated to SEL_W bits, which performs the wrap.
    function automatic arb_t rr_pick(input logic [NUM_REQ-1:0] req_vec,
                                     input logic [SEL_W-1:0]   ptr);
        arb_t             res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!res.found && req_vec[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_defs.svh
// ----------------------------------------------------------------------------
// mux8_rr_arbiter_defs.svh
// Shared constants for the 8-way round-robin arbiter and its bench:
// requester count, mux select width and FSM state encodings.
// ----------------------------------------------------------------------------
`ifndef MUX8_RR_ARBITER_DEFS_SVH
`define MUX8_RR_ARBITER_DEFS_SVH

`define MUX8_RR_NUM_REQ  8
`define MUX8_RR_SEL_W    3
`define MUX8_RR_ST_IDLE  1'b0
`define MUX8_RR_ST_BUSY  1'b1

`endif

// File: rtl/mux8_rr_arbiter_mux.sv
// ----------------------------------------------------------------------------
// multiplexer8to1
// Plain 8:1 single-bit multiplexer.
//   i : 8 data inputs, bit k selected when s == k
//   s : 3-bit select
//   y : selected data bit
// ----------------------------------------------------------------------------
module multiplexer8to1 (
    input  logic [7:0] i,
    input  logic [2:0] s,
    output logic       y
);

    assign y = i[s];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux8_rr_arbiter
// 8-requester round-robin arbiter steering one data bit through an 8:1 mux.
//   clk       : clock, all state on rising edge
//   rst_n     : synchronous active-low reset
//   req[7:0]  : per-requester request, held until its transfer
//   i[7:0]    : per-requester data bit
//   out_ready : downstream accepts out_data this cycle
//   grant     : registered one-hot grant, zero when idle
//   s         : registered select = index of granted requester
//   out_data  : i[s] while out_valid, else 0
//   out_valid : registered, high while a grant is held
// A grant is held (no preemption, no withdrawal) until out_valid & out_ready.
// On transfer the pointer moves past the served requester and re-arbitration
// happens in the same cycle, giving back-to-back grants.
// ----------------------------------------------------------------------------
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter logic [2:0] PTR_INIT = 3'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] i,
    input  logic       out_ready,
    output logic [7:0] grant,
    output logic [2:0] s,
    output logic       out_data,
    output logic       out_valid
);

    state_t             r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_s;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_out_valid;

    logic               w_xfer;
    logic [SEL_W-1:0]   w_arb_ptr;
    arb_t               w_arb;
    logic               w_mux_y;

    assign w_xfer = r_out_valid & out_ready;

    // On a transfer the search already starts past the served requester,
    // so the updated pointer is used in the same cycle it is written.
    assign w_arb_ptr = w_xfer ? (r_s + 3'd1) : r_ptr;

    always_comb begin
        w_arb = rr_pick(req, w_arb_ptr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= PTR_INIT;
            r_s         <= '0;
            r_grant     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb.found) begin
                        r_state     <= BUSY;
                        r_s         <= w_arb.idx;
                        r_grant     <= onehot(w_arb.idx);
                        r_out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_xfer) begin
                        r_ptr <= w_arb_ptr;
                        if (w_arb.found) begin
                            r_s     <= w_arb.idx;
                            r_grant <= onehot(w_arb.idx);
                        end else begin
                            r_state     <= IDLE;
                            r_grant     <= '0;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_grant     <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    multiplexer8to1 u_mux (
        .i (i),
        .s (r_s),
        .y (w_mux_y)
    );

    assign grant     = r_grant;
    assign s         = r_s;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid & w_mux_y;

endmodule
